// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer.
// Covers opcode encodings, the state encoding and opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T1W,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALTED,
        ST_FAULT
    } state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        return is_alu_op(op) || is_muldiv(op) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/reg_decoder.sv
// Register index to one-hot select decoder; flags indices beyond the register file.
module reg_decoder #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic [REG_IDX_W-1:0] i_idx,
    output logic [NUM_REGS-1:0]  o_onehot,
    output logic                 o_out_of_range
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_onehot[i] = (32'(i_idx) == 32'(i));
        end
        o_out_of_range = (32'(i_idx) >= 32'(NUM_REGS));
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch with memory handshake, decode, and
// sequencing of datapath strobes for ALU, MUL/DIV, NOP and HALT instructions.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int REG_IDX_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                MemReady,
    input  logic [DATA_W-1:0]   IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [OPC_W-1:0]    ALU_op,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                Done,
    output logic                Halted,
    output logic                Fault,
    output logic [CNT_W-1:0]    Retired
);

    localparam int OPC_LSB = DATA_W - OPC_W;
    localparam int RA_MSB  = OPC_LSB - 1;
    localparam int RB_MSB  = RA_MSB - REG_IDX_W;
    localparam int RC_MSB  = RB_MSB - REG_IDX_W;
    localparam int LOW_W   = RC_MSB + 1 - REG_IDX_W;
    localparam int TO_W    = $clog2(MEM_TIMEOUT + 1);

    state_t               r_state;
    state_t               w_next;
    state_t               w_after_retire;
    logic [TO_W-1:0]      r_wait;
    logic [CNT_W-1:0]     r_retired;

    logic [OPC_W-1:0]     w_opcode;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    logic [REG_IDX_W-1:0] w_rc;
    logic [NUM_REGS-1:0]  w_ra_oh;
    logic [NUM_REGS-1:0]  w_rb_oh;
    logic [NUM_REGS-1:0]  w_rc_oh;
    logic                 w_ra_oor;
    logic                 w_rb_oor;
    logic                 w_rc_oor;
    logic                 w_legal;
    logic                 w_timeout;
    logic                 w_unused_ir;

    assign w_opcode    = IR[DATA_W-1 -: OPC_W];
    assign w_ra        = IR[RA_MSB -: REG_IDX_W];
    assign w_rb        = IR[RB_MSB -: REG_IDX_W];
    assign w_rc        = IR[RC_MSB -: REG_IDX_W];
    assign w_unused_ir = ^IR[LOW_W-1:0];

    reg_decoder #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_ra (
        .i_idx          (w_ra),
        .o_onehot       (w_ra_oh),
        .o_out_of_range (w_ra_oor)
    );

    reg_decoder #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_rb (
        .i_idx          (w_rb),
        .o_onehot       (w_rb_oh),
        .o_out_of_range (w_rb_oor)
    );

    reg_decoder #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_rc (
        .i_idx          (w_rc),
        .o_onehot       (w_rc_oh),
        .o_out_of_range (w_rc_oor)
    );

    assign w_legal        = is_legal_op(w_opcode) && !w_ra_oor && !w_rb_oor && !w_rc_oor;
    assign w_timeout      = (r_wait == TO_W'(MEM_TIMEOUT - 1));
    assign w_after_retire = Run ? ST_T0 : ST_IDLE;
    assign Retired        = r_retired;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter only runs while stalled in T1W; any other state clears it.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_wait <= '0;
        end else if (r_state == ST_T1W && !MemReady) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_retired <= '0;
        end else if (Done) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next   = r_state;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        ALU_op   = '0;
        Rin      = '0;
        Rout     = '0;
        Done     = 1'b0;
        Halted   = 1'b0;
        Fault    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Run) w_next = ST_T0;
            end
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                ALU_op = OP_ADD;
                w_next = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                w_next  = MemReady ? ST_T2 : ST_T1W;
            end
            // Data arriving on the last allowed wait cycle still wins over the timeout.
            ST_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (MemReady)       w_next = ST_T2;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                if (!w_legal) begin
                    w_next = ST_FAULT;
                end else if (w_opcode == OP_NOP) begin
                    Done   = 1'b1;
                    w_next = w_after_retire;
                end else if (w_opcode == OP_HALT) begin
                    w_next = ST_HALTED;
                end else begin
                    Rout   = w_rb_oh;
                    Yin    = 1'b1;
                    w_next = ST_T4;
                end
            end
            ST_T4: begin
                Rout   = w_rc_oh;
                Zin    = 1'b1;
                ALU_op = w_opcode;
                w_next = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(w_opcode)) begin
                    LOin   = 1'b1;
                    w_next = ST_T6;
                end else begin
                    Rin    = w_ra_oh;
                    Done   = 1'b1;
                    w_next = w_after_retire;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
                w_next   = w_after_retire;
            end
            ST_HALTED: begin
                Halted = 1'b1;
            end
            ST_FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
